// File: rtl/teatris_pkg.sv
// Shared definitions for the teatris play sequencer.
// Contents: sequencer state enum, LFSR seed and tap mask, and the helper that
// turns a button index into the one-hot play pattern (index 0 -> MSB).
package teatris_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        BUSCA     = 2'd1,
        APRESENTA = 2'd2,
        FIM       = 2'd3
    } estado_seq_t;

    localparam logic [7:0] LFSR_SEMENTE = 8'hA5;
    // Feedback taps: bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;

    // Button index i out of n buttons -> bit n-1-i set (8-bit result, caller truncates).
    function automatic logic [7:0] indice_para_onehot(input logic [2:0] i, input int unsigned n);
        logic [2:0] pos;
        pos = 3'(n - 1) - i;
        return 8'd1 << pos;
    endfunction

endpackage

// File: rtl/teatris_lfsr8.sv
// 8-bit Fibonacci LFSR used for the pseudo-random play mode.
// Ports: clock, reset_n (sync, active-low, resets to LFSR_SEMENTE),
//        carregar (load semente), semente, passo (advance one step), valor.
module teatris_lfsr8
    import teatris_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       carregar,
    input  logic [7:0] semente,
    input  logic       passo,
    output logic [7:0] valor
);

    // Load has priority over step; a loaded seed is never zero by construction.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valor <= LFSR_SEMENTE;
        end else if (carregar) begin
            valor <= semente;
        end else if (passo) begin
            valor <= {valor[6:0], ^(valor & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/teatris_sequenciador_jogadas.sv
// Expected-play sequencer: produces the one-hot button pattern for the selected
// sequence, stepping under an iniciar/avancar handshake from the game FSM.
// Ports: clock, reset_n (sync, active-low); iniciar, sequencia, modo_aleatorio
// (latched on accepted start); avancar (advance, only while presenting);
// jogada / jogada_valida (expected play to the comparator); endereco (step index);
// fim (sequence exhausted); ocupado (fetching or presenting).
module teatris_sequenciador_jogadas
    import teatris_pkg::*;
#(
    parameter  int unsigned N_BOTOES     = 4,
    parameter  int unsigned LARGURA_END  = 4,
    parameter  int unsigned N_SEQUENCIAS = 4,
    localparam int unsigned LS           = (N_SEQUENCIAS > 1) ? $clog2(N_SEQUENCIAS) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iniciar,
    input  logic [LS-1:0]          sequencia,
    input  logic                   modo_aleatorio,
    input  logic                   avancar,
    output logic [N_BOTOES-1:0]    jogada,
    output logic                   jogada_valida,
    output logic [LARGURA_END-1:0] endereco,
    output logic                   fim,
    output logic                   ocupado
);

    localparam int unsigned LB = (N_BOTOES > 1) ? $clog2(N_BOTOES) : 1;
    localparam int unsigned LA = LARGURA_END + 2;
    localparam logic [LARGURA_END-1:0] ULTIMO = '1;

    estado_seq_t       estado;
    estado_seq_t       estado_prox;
    logic [LS-1:0]     s_reg;
    logic              modo_reg;
    logic              carregar_c;
    logic              passo_c;
    logic [LS-1:0]     s_mod_c;
    logic [LA-1:0]     soma_c;
    logic [LB-1:0]     indice_c;
    logic [7:0]        lfsr_valor;

    // Out-of-range selections fold back into the valid sequence range.
    assign s_mod_c = LS'(32'(sequencia) % N_SEQUENCIAS);

    teatris_lfsr8 u_lfsr (
        .clock    (clock),
        .reset_n  (reset_n),
        .carregar (carregar_c),
        .semente  (LFSR_SEMENTE ^ 8'(s_mod_c)),
        .passo    (passo_c & modo_reg),
        .valor    (lfsr_valor)
    );

    // Next-state logic; start and advance strobes decoded from the current state.
    always_comb begin
        estado_prox = estado;
        carregar_c  = 1'b0;
        passo_c     = 1'b0;
        unique case (estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    carregar_c  = 1'b1;
                    estado_prox = BUSCA;
                end
            end
            BUSCA: begin
                estado_prox = APRESENTA;
            end
            APRESENTA: begin
                if (avancar) begin
                    if (endereco == ULTIMO) begin
                        estado_prox = FIM;
                    end else begin
                        passo_c     = 1'b1;
                        estado_prox = BUSCA;
                    end
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Button index: deterministic (3*addr + s) mod N, or low bits of the LFSR.
    always_comb begin
        soma_c = LA'(3) * LA'(endereco) + LA'(s_reg);
        if (modo_reg) begin
            indice_c = LB'(32'(lfsr_valor) % N_BOTOES);
        end else begin
            indice_c = LB'(32'(soma_c) % N_BOTOES);
        end
    end

    // State, latched selection, address counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado        <= OCIOSO;
            s_reg         <= '0;
            modo_reg      <= 1'b0;
            endereco      <= '0;
            jogada        <= '0;
            jogada_valida <= 1'b0;
            fim           <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            estado        <= estado_prox;
            jogada_valida <= (estado_prox == APRESENTA);
            fim           <= (estado_prox == FIM);
            ocupado       <= (estado_prox == BUSCA) || (estado_prox == APRESENTA);
            if (carregar_c) begin
                s_reg    <= s_mod_c;
                modo_reg <= modo_aleatorio;
                endereco <= '0;
            end else if (passo_c) begin
                endereco <= endereco + LARGURA_END'(1);
            end
            // The play is captured only in BUSCA so it stays stable while presented.
            if (estado == BUSCA) begin
                jogada <= N_BOTOES'(indice_para_onehot(3'(indice_c), N_BOTOES));
            end
        end
    end

endmodule

// File: tb/tb_teatris_sequenciador_jogadas.sv
// Scoreboard bench for teatris_sequenciador_jogadas: two instances
// (4 buttons / 16 steps / 4 sequences, and 8 buttons / 8 steps / 3 sequences).
module tb_teatris_sequenciador_jogadas;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, modo;
    logic       ini_a, av_a, ini_b, av_b;
    logic [1:0] seq_a, seq_b;
    logic [3:0] jog_a;
    logic [7:0] jog_b;
    logic       val_a, fim_a, ocu_a, val_b, fim_b, ocu_b;
    logic [3:0] end_a;
    logic [2:0] end_b;

    teatris_sequenciador_jogadas #(.N_BOTOES(4), .LARGURA_END(4), .N_SEQUENCIAS(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .iniciar(ini_a), .sequencia(seq_a),
        .modo_aleatorio(modo), .avancar(av_a), .jogada(jog_a), .jogada_valida(val_a),
        .endereco(end_a), .fim(fim_a), .ocupado(ocu_a));

    teatris_sequenciador_jogadas #(.N_BOTOES(8), .LARGURA_END(3), .N_SEQUENCIAS(3)) dut_b (
        .clock(clock), .reset_n(reset_n), .iniciar(ini_b), .sequencia(seq_b),
        .modo_aleatorio(modo), .avancar(av_b), .jogada(jog_b), .jogada_valida(val_b),
        .endereco(end_b), .fim(fim_b), .ocupado(ocu_b));

    typedef struct {
        bit         eh_fim;
        logic [7:0] jog;
        int         ender;
    } evento_t;

    evento_t qa[$];
    evento_t qb[$];
    int checks   = 0;
    int failures = 0;

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    function automatic logic valida_de(input int id);  return (id == 0) ? val_a : val_b; endfunction
    function automatic logic fim_de(input int id);     return (id == 0) ? fim_a : fim_b; endfunction
    function automatic logic ocupado_de(input int id); return (id == 0) ? ocu_a : ocu_b; endfunction
    function automatic logic [7:0] jog_de(input int id);
        return (id == 0) ? {4'b0, jog_a} : jog_b;
    endfunction
    function automatic logic [31:0] end_de(input int id);
        return (id == 0) ? 32'(end_a) : 32'(end_b);
    endfunction

    task automatic poe(input int id, input logic ini, input logic av);
        if (id == 0) begin ini_a = ini; av_a = av; end
        else         begin ini_b = ini; av_b = av; end
    endtask

    task automatic poe_seq(input int id, input int s);
        if (id == 0) seq_a = 2'(s); else seq_b = 2'(s);
    endtask

    // Reference model: shift register with feedback from bits 7,5,4,3.
    function automatic logic [7:0] lfsr_prox(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Reference model: expected one-hot play for one step.
    function automatic logic [7:0] esperado(input int nb, input int s, input bit m,
                                            input int addr, input logic [7:0] l);
        int i;
        if (m) i = int'(l) % nb;
        else   i = (3 * addr + s) % nb;
        return 8'd1 << (nb - 1 - i);
    endfunction

    // Monitor: pops an expected event whenever a play is presented or the sequence ends.
    logic       pv[2];
    logic       pf[2];
    logic [7:0] jexp[2];
    int         eexp[2];
    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; pf[0] = 1'b0; pf[1] = 1'b0;
    end

    always @(negedge clock) begin
        for (int id = 0; id < 2; id++) begin
            evento_t ev;
            logic v, f;
            v = valida_de(id);
            f = fim_de(id);
            if ((v === 1'b1 && pv[id] !== 1'b1) || (f === 1'b1 && pf[id] !== 1'b1)) begin
                if (((id == 0) ? qa.size() : qb.size()) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_vazio dut%0d: got event with no expectation", id);
                end else begin
                    if (id == 0) ev = qa.pop_front(); else ev = qb.pop_front();
                    verifica($sformatf("tipo_evento%0d", id), 32'(f), 32'(ev.eh_fim));
                    verifica($sformatf("jogada%0d_end%0d", id, ev.ender), 32'(jog_de(id)), 32'(ev.jog));
                    verifica($sformatf("endereco%0d", id), end_de(id), 32'(ev.ender));
                    jexp[id] = ev.jog;
                    eexp[id] = ev.ender;
                end
            end else if (v === 1'b1) begin
                verifica($sformatf("jogada_estavel%0d", id), 32'(jog_de(id)), 32'(jexp[id]));
                verifica($sformatf("endereco_estavel%0d", id), end_de(id), 32'(eexp[id]));
            end
            pv[id] = v;
            pf[id] = f;
        end
    end

    // Runs one full sequence; aborta_em >= 0 applies a one-cycle reset at that address.
    task automatic roda(input int id, input int s, input bit m, input int gap_max, input int aborta_em);
        int nb, n, nseq, se, t, g;
        logic [7:0] l, lm;
        evento_t ev;
        nb   = (id == 0) ? 4 : 8;
        n    = (id == 0) ? 16 : 8;
        nseq = (id == 0) ? 4 : 3;
        se   = s % nseq;
        l    = 8'hA5 ^ 8'(se);
        lm   = l;
        for (int a = 0; a < n; a++) begin
            ev.eh_fim = 1'b0;
            ev.jog    = esperado(nb, se, m, a, l);
            ev.ender  = a;
            if (id == 0) qa.push_back(ev); else qb.push_back(ev);
            if (m && a < n - 1) l = lfsr_prox(l);
        end
        ev.eh_fim = 1'b1;
        ev.ender  = n - 1;
        if (id == 0) qa.push_back(ev); else qb.push_back(ev);

        @(posedge clock); #1;
        poe_seq(id, s);
        modo = m;
        poe(id, 1'b1, 1'b0);
        @(posedge clock); #1;
        poe(id, 1'b0, 1'b0);
        verifica("busca_ocupado", 32'(ocupado_de(id)), 32'd1);
        verifica("busca_sem_valida", 32'(valida_de(id)), 32'd0);
        @(posedge clock); #1;
        verifica("latencia_dois_ciclos", 32'(valida_de(id)), 32'd1);

        for (int a = 0; a < n; a++) begin
            t = 0;
            while (valida_de(id) !== 1'b1 && t < 20) begin
                @(posedge clock); #1;
                t++;
            end
            verifica("espera_valida", 32'(valida_de(id)), 32'd1);
            if (t >= 20) return;

            if (a == aborta_em) begin
                reset_n = 1'b0;
                @(posedge clock); #1;
                reset_n = 1'b1;
                verifica("rst_jogada", 32'(jog_de(id)), 32'd0);
                verifica("rst_valida", 32'(valida_de(id)), 32'd0);
                verifica("rst_endereco", end_de(id), 32'd0);
                verifica("rst_fim", 32'(fim_de(id)), 32'd0);
                verifica("rst_ocupado", 32'(ocupado_de(id)), 32'd0);
                if (id == 0) qa.delete(); else qb.delete();
                repeat (3) begin
                    poe(id, 1'b0, 1'b1);
                    @(posedge clock); #1;
                    poe(id, 1'b0, 1'b0);
                    verifica("rst_avancar_ignorado", 32'({valida_de(id), ocupado_de(id)}), 32'd0);
                end
                return;
            end

            // Start requests while presenting must be ignored.
            if (a == 5 || $urandom_range(0, 3) == 0) begin
                poe_seq(id, int'($urandom_range(0, 3)));
                poe(id, 1'b1, 1'b0);
                @(posedge clock); #1;
                poe(id, 1'b0, 1'b0);
                verifica("ini_ignorado_end", end_de(id), 32'(a));
                verifica("ini_ignorado_valida", 32'(valida_de(id)), 32'd1);
            end
            g = int'($urandom_range(0, gap_max));
            repeat (g) begin @(posedge clock); #1; end

            poe(id, ($urandom_range(0, 4) == 0), 1'b1);
            @(posedge clock); #1;
            poe(id, 1'b0, 1'b0);
            if (a < n - 1) begin
                verifica("avanco_busca", 32'({valida_de(id), ocupado_de(id)}), 32'b01);
                verifica("avanco_end", end_de(id), 32'(a + 1));
                if (m) lm = lfsr_prox(lm);
            end else begin
                verifica("ultimo_fim", 32'({fim_de(id), valida_de(id), ocupado_de(id)}), 32'b100);
                verifica("ultimo_end", end_de(id), 32'(n - 1));
            end
            if (id == 0) verifica("lfsr", 32'(dut_a.u_lfsr.valor), 32'(lm));
        end

        poe(id, 1'b0, 1'b1);
        @(posedge clock); #1;
        poe(id, 1'b0, 1'b0);
        verifica("fim_avancar_ignorado", 32'({fim_de(id), valida_de(id)}), 32'b10);
        verifica("fim_end_mantido", end_de(id), 32'(n - 1));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; modo = 1'b0;
        ini_a = 1'b0; av_a = 1'b0; ini_b = 1'b0; av_b = 1'b0;
        seq_a = 2'd0; seq_b = 2'd0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        verifica("reset_a", 32'({jog_a, val_a, end_a, fim_a, ocu_a}), 32'd0);
        verifica("reset_b", 32'({jog_b, val_b, end_b, fim_b, ocu_b}), 32'd0);
        verifica("reset_lfsr", 32'(dut_a.u_lfsr.valor), 32'hA5);

        roda(0, 0, 1'b0, 0, -1);
        roda(0, 1, 1'b0, 2, -1);
        roda(0, 0, 1'b1, 1, -1);
        roda(0, 2, 1'b0, 1, 7);
        repeat (4) roda(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3, -1);

        roda(1, 0, 1'b0, 0, -1);
        roda(1, 3, 1'b0, 1, -1);
        roda(1, int'($urandom_range(0, 3)), 1'b1, 2, -1);

        repeat (3) @(posedge clock);
        #1;
        verifica("fila_vazia_a", 32'(qa.size()), 32'd0);
        verifica("fila_vazia_b", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
